// File: rtl/tone_pkg.sv
// Note index constants, command payload and the half-period lookup shared by the tone bank.
package tone_pkg;
    localparam int unsigned NOTE_W    = 4;
    localparam int unsigned HP_W      = 18;
    localparam int unsigned NUM_NOTES = 13;
    localparam int unsigned CMD_CH_W  = 3;

    localparam logic [NOTE_W-1:0] REST = 4'd0;
    localparam logic [NOTE_W-1:0] C4   = 4'd1;
    localparam logic [NOTE_W-1:0] CS4  = 4'd2;
    localparam logic [NOTE_W-1:0] D4   = 4'd3;
    localparam logic [NOTE_W-1:0] DS4  = 4'd4;
    localparam logic [NOTE_W-1:0] E4   = 4'd5;
    localparam logic [NOTE_W-1:0] F4   = 4'd6;
    localparam logic [NOTE_W-1:0] FS4  = 4'd7;
    localparam logic [NOTE_W-1:0] G4   = 4'd8;
    localparam logic [NOTE_W-1:0] GS4  = 4'd9;
    localparam logic [NOTE_W-1:0] A4   = 4'd10;
    localparam logic [NOTE_W-1:0] AS4  = 4'd11;
    localparam logic [NOTE_W-1:0] B4   = 4'd12;
    localparam logic [NOTE_W-1:0] C5   = 4'd13;

    typedef logic [15:0][HP_W-1:0] hp_lut_t;

    typedef struct packed {
        logic [CMD_CH_W-1:0] ch;
        logic [NOTE_W-1:0]   idx;
        logic                on;
    } note_cmd_t;

    // Equal-tempered pitch in centi-hertz (A4 = 440.00 Hz); 0 marks a rest.
    function automatic logic [15:0] note_fchz(input logic [NOTE_W-1:0] idx);
        case (idx)
            C4:      return 16'd26163;
            CS4:     return 16'd27718;
            D4:      return 16'd29366;
            DS4:     return 16'd31113;
            E4:      return 16'd32963;
            F4:      return 16'd34923;
            FS4:     return 16'd36999;
            G4:      return 16'd39200;
            GS4:     return 16'd41530;
            A4:      return 16'd44000;
            AS4:     return 16'd46616;
            B4:      return 16'd49388;
            C5:      return 16'd52325;
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic is_tone(input logic [NOTE_W-1:0] idx);
        return (idx >= C4) && (32'(idx) <= NUM_NOTES);
    endfunction

    // Half-period minus one: round(clk_hz / (2 f)) - 1, done in centi-hertz.
    function automatic logic [HP_W-1:0] note_hp(input logic [NOTE_W-1:0] idx,
                                                input logic [63:0]       clk_hz);
        logic [63:0] f;
        logic [63:0] q;
        f = 64'(note_fchz(idx));
        q = 64'd0;
        if (f == 64'd0) begin
            return '0;
        end
        q = (clk_hz * 64'd100 + f) / (64'd2 * f);
        return HP_W'(q - 64'd1);
    endfunction

    function automatic hp_lut_t hp_table(input logic [63:0] clk_hz);
        hp_lut_t t;
        for (int i = 0; i < 16; i++) begin
            t[i] = note_hp(NOTE_W'(i), clk_hz);
        end
        return t;
    endfunction
endpackage

// File: rtl/tone_channel.sv
// One square-wave voice: reloadable half-period counter driving a toggling output.
module tone_channel
    import tone_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET,
    input  logic            i_load,
    input  logic            i_stop,
    input  logic [HP_W-1:0] i_hp,
    output logic            o_tone,
    output logic            o_active
);
    logic [HP_W-1:0] r_hp;
    logic [HP_W-1:0] r_cnt;
    logic            r_tone;
    logic            r_active;

    // A load always restarts the phase, even when the same note is already sounding.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_hp     <= '0;
            r_cnt    <= '0;
            r_tone   <= 1'b0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_hp     <= i_hp;
            r_cnt    <= '0;
            r_tone   <= 1'b0;
            r_active <= 1'b1;
        end else if (i_stop) begin
            r_cnt    <= '0;
            r_tone   <= 1'b0;
            r_active <= 1'b0;
        end else if (r_active) begin
            if (r_cnt == r_hp) begin
                r_cnt  <= '0;
                r_tone <= ~r_tone;
            end else begin
                r_cnt  <= r_cnt + HP_W'(1);
            end
        end
    end

    assign o_tone   = r_tone;
    assign o_active = r_active;
endmodule

// File: rtl/tone_bank.sv
// Bank of independent square-wave tone channels plus a free-running tempo beat generator.
module tone_bank
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned BEAT_W = 28
) (
    input  logic                                            CLK,
    input  logic                                            RESET,
    input  logic                                            note_valid,
    output logic                                            note_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  note_ch,
    input  logic [3:0]                                      note_idx,
    input  logic                                            note_on,
    input  logic [BEAT_W-1:0]                               tempo_div,
    output logic [NUM_CH-1:0]                               tone_out,
    output logic [NUM_CH-1:0]                               ch_active,
    output logic                                            beat_tick,
    output logic                                            beat_level
);
    localparam hp_lut_t HP_LUT = hp_table(64'(CLK_HZ));

    logic              w_accept;
    logic              w_play;
    logic              w_mute;
    note_cmd_t         w_cmd;
    logic [HP_W-1:0]   w_hp;
    logic [NUM_CH-1:0] w_load;
    logic [NUM_CH-1:0] w_stop;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic              r_beat_tick;
    logic              r_beat_level;

    assign note_ready = ~RESET;
    assign w_accept   = note_valid & note_ready;
    assign w_cmd      = '{ch: CMD_CH_W'(note_ch), idx: note_idx, on: note_on};
    assign w_play     = w_accept & w_cmd.on & is_tone(w_cmd.idx);
    assign w_mute     = w_accept & ~w_play;
    assign w_hp       = HP_LUT[w_cmd.idx];

    // Out-of-range channel numbers match no instance, so they are accepted and dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic w_hit;
        assign w_hit     = (w_cmd.ch == CMD_CH_W'(i));
        assign w_load[i] = w_play & w_hit;
        assign w_stop[i] = w_mute & w_hit;

        tone_channel u_ch (
            .CLK      (CLK),
            .RESET    (RESET),
            .i_load   (w_load[i]),
            .i_stop   (w_stop[i]),
            .i_hp     (w_hp),
            .o_tone   (tone_out[i]),
            .o_active (ch_active[i])
        );
    end

    // Compare with >= so a live drop of tempo_div below the count fires at once.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_beat_cnt   <= '0;
            r_beat_tick  <= 1'b0;
            r_beat_level <= 1'b0;
        end else if (r_beat_cnt >= tempo_div) begin
            r_beat_cnt   <= '0;
            r_beat_tick  <= 1'b1;
            r_beat_level <= ~r_beat_level;
        end else begin
            r_beat_cnt   <= r_beat_cnt + BEAT_W'(1);
            r_beat_tick  <= 1'b0;
        end
    end

    assign beat_tick  = r_beat_tick;
    assign beat_level = r_beat_level;
endmodule

// File: tb/tb_tone_bank.sv
// Directed bench for tone_bank at a 1 MHz clock: A4 period 1136, C4 1911, C5 956 cycles.
module tb_tone_bank;
    import tone_pkg::*;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned BEAT_W = 16;

    logic              CLK;
    logic              RESET;
    logic              note_valid;
    logic              note_ready;
    logic [CH_W-1:0]   note_ch;
    logic [3:0]        note_idx;
    logic              note_on;
    logic [BEAT_W-1:0] tempo_div;
    logic [NUM_CH-1:0] tone_out;
    logic [NUM_CH-1:0] ch_active;
    logic              beat_tick;
    logic              beat_level;

    int n_checks = 0;
    int n_pass   = 0;

    tone_bank #(.CLK_HZ(1_000_000), .NUM_CH(NUM_CH), .BEAT_W(BEAT_W)) u_dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .note_ch    (note_ch),
        .note_idx   (note_idx),
        .note_on    (note_on),
        .tempo_div  (tempo_div),
        .tone_out   (tone_out),
        .ch_active  (ch_active),
        .beat_tick  (beat_tick),
        .beat_level (beat_level)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input int ch, input logic [3:0] idx, input logic on);
        note_valid = 1'b1;
        note_ch    = CH_W'(ch);
        note_idx   = idx;
        note_on    = on;
        tick();
        note_valid = 1'b0;
    endtask

    task automatic wait_toggle(input int ch, output int n);
        logic prev;
        prev = tone_out[ch];
        n = 0;
        while (n < 5000) begin
            tick();
            n++;
            if (tone_out[ch] !== prev) return;
        end
        n = -1;
    endtask

    task automatic cycles_to_tick(output int n);
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (beat_tick === 1'b1) return;
        end
        n = -1;
    endtask

    task automatic test_hp_table();
        n_checks++;
        if (note_hp(A4, 64'd100_000_000) !== 18'd113635)
            $display("FAIL hp_a4_100M got %0d want 113635", note_hp(A4, 64'd100_000_000));
        else n_pass++;
        n_checks++;
        if (note_hp(C4, 64'd100_000_000) !== 18'd191109)
            $display("FAIL hp_c4_100M got %0d want 191109", note_hp(C4, 64'd100_000_000));
        else n_pass++;
        n_checks++;
        if (note_hp(C5, 64'd100_000_000) !== 18'd95556)
            $display("FAIL hp_c5_100M got %0d want 95556", note_hp(C5, 64'd100_000_000));
        else n_pass++;
        n_checks++;
        if (note_hp(A4, 64'd1_000_000) !== 18'd1135)
            $display("FAIL hp_a4_1M got %0d want 1135", note_hp(A4, 64'd1_000_000));
        else n_pass++;
    endtask

    task automatic test_reset();
        int n;
        RESET = 1'b1; note_valid = 1'b0; note_ch = '0; note_idx = '0; note_on = 1'b0;
        tempo_div = BEAT_W'(9);
        repeat (3) tick();
        n_checks++;
        if ({tone_out, ch_active, beat_tick, beat_level, note_ready} !== 9'b0)
            $display("FAIL reset_outputs got %b want 000000000",
                     {tone_out, ch_active, beat_tick, beat_level, note_ready});
        else n_pass++;
        RESET = 1'b0;
        #1;
        n_checks++;
        if (note_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", note_ready);
        else n_pass++;
        cycles_to_tick(n);
        n_checks++;
        if (n !== 10) $display("FAIL reset_first_beat got %0d want 10", n);
        else n_pass++;
    endtask

    task automatic test_a4();
        int n;
        send(0, A4, 1'b1);
        n_checks++;
        if (tone_out !== 3'b000 || ch_active !== 3'b001)
            $display("FAIL a4_start got tone %b act %b want 000 001", tone_out, ch_active);
        else n_pass++;
        wait_toggle(0, n);
        n_checks++;
        if (n !== 1136 || tone_out[0] !== 1'b1)
            $display("FAIL a4_first_toggle got %0d/%b want 1136/1", n, tone_out[0]);
        else n_pass++;
        wait_toggle(0, n);
        n_checks++;
        if (n !== 1136) $display("FAIL a4_second_toggle got %0d want 1136", n);
        else n_pass++;
    endtask

    task automatic test_two_ch();
        int t0[2];
        int t1[2];
        int t2[2];
        int k0, k1, k2;
        logic [NUM_CH-1:0] prev;
        t0 = '{0, 0}; t1 = '{0, 0}; t2 = '{0, 0};
        k0 = 0; k1 = 0; k2 = 0;
        send(1, C4, 1'b1);
        send(2, C5, 1'b1);
        n_checks++;
        if (ch_active !== 3'b111) $display("FAIL two_ch_active got %b want 111", ch_active);
        else n_pass++;
        prev = tone_out;
        for (int c = 1; c <= 4000; c++) begin
            tick();
            if (tone_out[0] !== prev[0] && k0 < 2) begin t0[k0] = c; k0++; end
            if (tone_out[1] !== prev[1] && k1 < 2) begin t1[k1] = c; k1++; end
            if (tone_out[2] !== prev[2] && k2 < 2) begin t2[k2] = c; k2++; end
            prev = tone_out;
        end
        n_checks++;
        if (t1[0] !== 1910 || t1[1] - t1[0] !== 1911)
            $display("FAIL c4_ch1 got first %0d period %0d want 1910 1911", t1[0], t1[1] - t1[0]);
        else n_pass++;
        n_checks++;
        if (t2[0] !== 956 || t2[1] - t2[0] !== 956)
            $display("FAIL c5_ch2 got first %0d period %0d want 956 956", t2[0], t2[1] - t2[0]);
        else n_pass++;
        n_checks++;
        if (k0 !== 2 || t0[1] - t0[0] !== 1136 || ch_active[0] !== 1'b1)
            $display("FAIL ch0_untouched got k %0d period %0d act %b want 2 1136 1",
                     k0, t0[1] - t0[0], ch_active[0]);
        else n_pass++;
    endtask

    task automatic test_restart();
        int n;
        wait_toggle(0, n);
        if (tone_out[0] !== 1'b1) wait_toggle(0, n);
        repeat (300) tick();
        n_checks++;
        if (tone_out[0] !== 1'b1) $display("FAIL restart_pre_high got %b want 1", tone_out[0]);
        else n_pass++;
        send(0, A4, 1'b1);
        n_checks++;
        if (tone_out[0] !== 1'b0 || ch_active[0] !== 1'b1)
            $display("FAIL restart_phase got tone %b act %b want 0 1", tone_out[0], ch_active[0]);
        else n_pass++;
        wait_toggle(0, n);
        n_checks++;
        if (n !== 1136) $display("FAIL restart_period got %0d want 1136", n);
        else n_pass++;
    endtask

    task automatic test_stop();
        int n;
        repeat (100) tick();
        n_checks++;
        if (tone_out[0] !== 1'b1) $display("FAIL stop_pre_high got %b want 1", tone_out[0]);
        else n_pass++;
        send(0, A4, 1'b0);
        n_checks++;
        if (tone_out[0] !== 1'b0 || ch_active !== 3'b110)
            $display("FAIL stop_off got tone %b act %b want 0 110", tone_out[0], ch_active);
        else n_pass++;
        repeat (1500) tick();
        n_checks++;
        if (tone_out[0] !== 1'b0) $display("FAIL stop_hold got %b want 0", tone_out[0]);
        else n_pass++;
        send(0, A4, 1'b1);
        wait_toggle(0, n);
        send(0, REST, 1'b1);
        n_checks++;
        if (n !== 1136 || tone_out[0] !== 1'b0 || ch_active !== 3'b110)
            $display("FAIL stop_rest0 got n %0d tone %b act %b want 1136 0 110",
                     n, tone_out[0], ch_active);
        else n_pass++;
        send(0, A4, 1'b1);
        send(0, 4'd14, 1'b1);
        n_checks++;
        if (ch_active !== 3'b110) $display("FAIL stop_rest14 got %b want 110", ch_active);
        else n_pass++;
    endtask

    task automatic test_bad_ch();
        int n;
        send(3, A4, 1'b1);
        n_checks++;
        if (ch_active !== 3'b110 || tone_out[0] !== 1'b0)
            $display("FAIL bad_ch_on got act %b tone0 %b want 110 0", ch_active, tone_out[0]);
        else n_pass++;
        send(3, REST, 1'b0);
        n_checks++;
        if (ch_active !== 3'b110) $display("FAIL bad_ch_off got %b want 110", ch_active);
        else n_pass++;
        wait_toggle(2, n);
        n_checks++;
        if (n < 1 || n > 956) $display("FAIL bad_ch_ch2_runs got %0d want 1..956", n);
        else n_pass++;
    endtask

    task automatic test_beat();
        int n;
        logic lvl;
        cycles_to_tick(n);
        lvl = beat_level;
        cycles_to_tick(n);
        n_checks++;
        if (n !== 10 || beat_level !== ~lvl)
            $display("FAIL beat_period got %0d lvl %b want 10 %b", n, beat_level, ~lvl);
        else n_pass++;
        cycles_to_tick(n);
        n_checks++;
        if (n !== 10 || beat_level !== lvl)
            $display("FAIL beat_level_period got %0d lvl %b want 10 %b", n, beat_level, lvl);
        else n_pass++;
        repeat (7) tick();
        n_checks++;
        if (beat_tick !== 1'b0) $display("FAIL beat_cnt7_quiet got %b want 0", beat_tick);
        else n_pass++;
        tempo_div = BEAT_W'(3);
        tick();
        n_checks++;
        if (beat_tick !== 1'b1) $display("FAIL beat_lower_tempo got %b want 1", beat_tick);
        else n_pass++;
        cycles_to_tick(n);
        n_checks++;
        if (n !== 4) $display("FAIL beat_period4 got %0d want 4", n);
        else n_pass++;
        tempo_div = '0;
        n = 0;
        repeat (3) begin
            tick();
            if (beat_tick === 1'b1) n++;
        end
        n_checks++;
        if (n !== 3) $display("FAIL beat_tempo0 got %0d ticks want 3", n);
        else n_pass++;
        tempo_div = BEAT_W'(9);
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        while (beat_level !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        n_checks++;
        if (beat_level !== 1'b1 || ch_active !== 3'b110)
            $display("FAIL areset_pre got lvl %b act %b want 1 110", beat_level, ch_active);
        else n_pass++;
        #3;
        RESET = 1'b1;
        #1;
        n_checks++;
        if ({tone_out, ch_active, beat_tick, beat_level, note_ready} !== 9'b0)
            $display("FAIL areset_immediate got %b want 000000000",
                     {tone_out, ch_active, beat_tick, beat_level, note_ready});
        else n_pass++;
        tick();
        tick();
        RESET = 1'b0;
        cycles_to_tick(n);
        n_checks++;
        if (n !== 10) $display("FAIL areset_first_beat got %0d want 10", n);
        else n_pass++;
        n_checks++;
        if (ch_active !== 3'b000 || tone_out !== 3'b000)
            $display("FAIL areset_silent got act %b tone %b want 000 000", ch_active, tone_out);
        else n_pass++;
    endtask

    initial begin
        test_hp_table();
        test_reset();
        test_a4();
        test_two_ch();
        test_restart();
        test_stop();
        test_bad_ch();
        test_beat();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/tone_bank.md
TONE_BANK -- requirements
Module: tone_bank

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter NUM_CH, default 4, number of independent tone channels (1..8).
REQ-003 SHALL have parameter BEAT_W, default 28, width of the tempo divider.
REQ-004 SHALL have port CLK  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port note_valid  input  1  note command present.
REQ-007 SHALL have port note_ready  output  1  command accepted when high with note_valid.
REQ-008 SHALL have port note_ch  input  $clog2(NUM_CH) (min 1)  target channel.
REQ-009 SHALL have port note_idx  input  4  note index: 0 rest, 1..13 chromatic C4..C5, 14..15 rest.
REQ-010 SHALL have port note_on  input  1  1 start note, 0 stop channel.
REQ-011 SHALL have port tempo_div  input  BEAT_W  beat half-period in CLK cycles minus 1.
REQ-012 SHALL have port tone_out  output  NUM_CH  per-channel square wave.
REQ-013 SHALL have port ch_active  output  NUM_CH  per-channel sounding flag.
REQ-014 SHALL have port beat_tick  output  1  one-cycle pulse per beat half-period.
REQ-015 SHALL have port beat_level  output  1  toggles on every beat_tick (QUARTER_BEAT equivalent).

Function
REQ-016 SHALL compute half-period HP(n) = round(CLK_HZ / (2*f(n))) - 1, f equal-tempered, A4 = 440 Hz; at default: C4 191109, A4 113635, C5 95556; all HP fit in 18 bits.
REQ-017 SHALL drive note_ready high every cycle RESET is low; a command is accepted on any edge with note_valid && note_ready.
REQ-018 SHALL, on accept with note_on=1 and note_idx in 1..13: load HP into channel note_ch, clear its counter, force its tone_out to 0, set ch_active=1, all at that edge.
REQ-019 SHALL, on accept with note_on=0 or a rest index: clear counter, tone_out=0, ch_active=0 for note_ch.
REQ-020 SHALL, per active channel each edge: if counter == HP then counter=0 and tone_out toggles, else counter increments; first toggle at accept edge + HP + 1.
REQ-021 SHALL hold an inactive channel at tone_out=0, counter=0.
REQ-022 SHALL restart phase (REQ-018) when a new note arrives on an already active channel, including the same note.
REQ-023 SHALL ignore note_ch >= NUM_CH (accepted, no state change).
REQ-024 SHALL leave channels other than note_ch unaffected by a command.
REQ-025 SHALL run the beat counter continuously: when count >= tempo_div, count=0, beat_tick=1 for one cycle, beat_level toggles; else count increments, beat_tick=0.
REQ-026 SHALL treat tempo_div sampled live; lowering it below the current count fires a tick on the next edge (no wrap overrun); tempo_div=0 gives beat_tick every cycle.
REQ-027 SHALL register all outputs (no combinational input-to-output paths except note_ready from RESET).

Reset
REQ-028 SHALL, while RESET high, force tone_out=0, ch_active=0, beat_tick=0, beat_level=0, all counters and HP registers 0, note_ready=0.
REQ-029 SHALL abort any sounding note on RESET mid-operation; first beat_tick after release follows tempo_div+1 edges.

Structure
REQ-030 SHALL place note index constants (REST, C4..C5), NUM_NOTES=13, and the HP table function of CLK_HZ in shared package tone_pkg.
REQ-031 SHALL implement one channel as sub-module tone_channel (load, stop, HP, tone_out, active), instantiated NUM_CH times by generate; beat counter stays in tone_bank.

Verification
REQ-032 SHALL test: reset release, A4 note_on on ch0 -> tone_out[0] toggles every 113636 cycles, ch_active[0]=1.
REQ-033 SHALL test: C4 ch1 and C5 ch2 same period -> independent periods 191110/95557 cycles, ch0 untouched.
REQ-034 SHALL test: note_on=0 to ch0 mid high phase -> tone_out[0]=0, ch_active[0]=0 next edge; rest index 0 same result.
REQ-035 SHALL test: tempo_div=9 -> beat_tick every 10 cycles, beat_level period 20; change to 3 when count=7 -> tick on next edge.
REQ-036 SHALL test: RESET asserted asynchronously mid-note -> all outputs 0 immediately; note_ch=NUM_CH command -> no change.
